// File: rtl/led_enc_pkg.sv
// Shared state encoding and default waveform timing for the LED bit encoder.
// Latency: none (declarations only).
// Backpressure: n/a.
package led_enc_pkg;

  // Default waveform timing in clk cycles (800 kHz LED protocol at 40 MHz).
  localparam int DEF_T0H_CYC   = 16;
  localparam int DEF_T1H_CYC   = 32;
  localparam int DEF_BIT_CYC   = 50;
  localparam int DEF_LATCH_CYC = 2000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } enc_state_e;

endpackage

// File: rtl/led_bit_timer.sv
// Generates one LED bit: high for T0H/T1H cycles, low for the rest of BIT_CYC.
// Latency: level rises the cycle after start; done marks the final cycle of the bit.
// Backpressure: none; start may coincide with done for gapless back-to-back bits.
module led_bit_timer
  import led_enc_pkg::*;
#(
  parameter int T0H_CYC = DEF_T0H_CYC,
  parameter int T1H_CYC = DEF_T1H_CYC,
  parameter int BIT_CYC = DEF_BIT_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic bit_val,
  output logic done,
  output logic level
);

  localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYC - 1);
  localparam logic [CW:0]   T0H_W    = (CW + 1)'(T0H_CYC);
  localparam logic [CW:0]   T1H_W    = (CW + 1)'(T1H_CYC);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0]   cnt_nxt;
  logic          active_q, active_d;
  logic          level_q, level_d;
  logic          bit_q, bit_d;

  // Bit period counter and registered output level; a new start overrides the terminal cycle.
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    level_d  = level_q;
    bit_d    = bit_q;
    cnt_nxt  = {1'b0, cnt_q} + 1'b1;
    done     = active_q && (cnt_q == CNT_LAST);
    if (start) begin
      active_d = 1'b1;
      cnt_d    = '0;
      bit_d    = bit_val;
      level_d  = 1'b1;
    end else if (active_q) begin
      if (done) begin
        active_d = 1'b0;
        level_d  = 1'b0;
      end else begin
        cnt_d   = cnt_q + 1'b1;
        level_d = cnt_nxt < (bit_q ? T1H_W : T0H_W);
      end
    end
  end

  // Timer state register; reset aborts any bit in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      level_q  <= 1'b0;
      bit_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      level_q  <= level_d;
      bit_q    <= bit_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/led_bit_encoder.sv
// Serialises pixel bytes MSB first into the single-wire LED waveform, then latches the chain.
// Latency: led_out rises 2 cycles after the accepting edge from IDLE, 1 cycle after a LATCH ends.
// Backpressure: one-byte holding register; data_ready low while it is full.
// Option: define LED_ENC_IDLE_LATCH_EN to close a frame after LATCH_CYC idle cycles following an underrun.
module led_bit_encoder
  import led_enc_pkg::*;
#(
  parameter int T0H_CYC   = DEF_T0H_CYC,
  parameter int T1H_CYC   = DEF_T1H_CYC,
  parameter int BIT_CYC   = DEF_BIT_CYC,
  parameter int LATCH_CYC = DEF_LATCH_CYC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic       data_last,
  output logic       data_ready,
  output logic       led_out,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam int LW = $clog2(LATCH_CYC + 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(LATCH_CYC - 1);

  enc_state_e    state_q, state_d;
  logic [7:0]    hold_dat_q, hold_dat_d;
  logic          hold_full_q, hold_full_d;
  logic          hold_last_q, hold_last_d;
  logic [7:0]    shift_q, shift_d;
  logic          shift_last_q, shift_last_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic          kick_q, kick_d;
  logic [LW-1:0] lat_cnt_q, lat_cnt_d;
  logic          rdy_en_q, rdy_en_d;
`ifdef LED_ENC_IDLE_LATCH_EN
  logic          idle_arm_q, idle_arm_d;
`endif

  logic accept;
  logic load;
  logic timer_start;
  logic timer_bit;
  logic timer_done;
  logic frame_done_c;
  logic underrun_c;

  led_bit_timer #(
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC),
    .BIT_CYC (BIT_CYC)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .start   (timer_start),
    .bit_val (timer_bit),
    .done    (timer_done),
    .level   (led_out)
  );

  assign data_ready = rdy_en_q && !hold_full_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_c;
  assign underrun   = underrun_c;

  // Next-state logic: byte handoff from the holding register, bit sequencing and latch timing.
  always_comb begin
    state_d      = state_q;
    hold_dat_d   = hold_dat_q;
    hold_full_d  = hold_full_q;
    hold_last_d  = hold_last_q;
    shift_d      = shift_q;
    shift_last_d = shift_last_q;
    bit_idx_d    = bit_idx_q;
    kick_d       = 1'b0;
    lat_cnt_d    = lat_cnt_q;
    rdy_en_d     = 1'b1;
`ifdef LED_ENC_IDLE_LATCH_EN
    idle_arm_d   = idle_arm_q;
`endif
    accept       = data_valid && data_ready;
    load         = 1'b0;
    timer_start  = 1'b0;
    timer_bit    = shift_q[7];
    frame_done_c = 1'b0;
    underrun_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          // Shifter loads now; the first bit is kicked off next cycle.
          load    = 1'b1;
          kick_d  = 1'b1;
          state_d = ST_SHIFT;
        end
`ifdef LED_ENC_IDLE_LATCH_EN
        else if (idle_arm_q) begin
          if (lat_cnt_q == LAT_LAST) begin
            frame_done_c = 1'b1;
            idle_arm_d   = 1'b0;
            lat_cnt_d    = '0;
          end else begin
            lat_cnt_d = lat_cnt_q + 1'b1;
          end
        end
        if (accept) begin
          idle_arm_d = 1'b0;
          lat_cnt_d  = '0;
        end
`endif
      end
      ST_SHIFT: begin
        if (kick_q) begin
          timer_start = 1'b1;
          timer_bit   = shift_q[7];
        end else if (timer_done) begin
          if (bit_idx_q != 3'd7) begin
            timer_start = 1'b1;
            timer_bit   = shift_q[6];
            shift_d     = {shift_q[6:0], 1'b0};
            bit_idx_d   = bit_idx_q + 3'd1;
          end else if (shift_last_q) begin
            state_d   = ST_LATCH;
            lat_cnt_d = '0;
          end else if (hold_full_q) begin
            load        = 1'b1;
            timer_start = 1'b1;
            timer_bit   = hold_dat_q[7];
          end else begin
            state_d    = ST_IDLE;
            underrun_c = 1'b1;
`ifdef LED_ENC_IDLE_LATCH_EN
            idle_arm_d = 1'b1;
            lat_cnt_d  = '0;
`endif
          end
        end
      end
      ST_LATCH: begin
        if (lat_cnt_q == LAT_LAST) begin
          frame_done_c = 1'b1;
          if (hold_full_q) begin
            // Byte accepted during the latch starts on the very next cycle.
            load        = 1'b1;
            timer_start = 1'b1;
            timer_bit   = hold_dat_q[7];
            state_d     = ST_SHIFT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      shift_d      = hold_dat_q;
      shift_last_d = hold_last_q;
      bit_idx_d    = 3'd0;
      hold_full_d  = 1'b0;
    end
    if (accept) begin
      hold_dat_d  = data_in;
      hold_last_d = data_last;
      hold_full_d = 1'b1;
    end
  end

  // State registers; reset discards any partial byte and the holding register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      hold_dat_q   <= '0;
      hold_full_q  <= 1'b0;
      hold_last_q  <= 1'b0;
      shift_q      <= '0;
      shift_last_q <= 1'b0;
      bit_idx_q    <= '0;
      kick_q       <= 1'b0;
      lat_cnt_q    <= '0;
      rdy_en_q     <= 1'b0;
`ifdef LED_ENC_IDLE_LATCH_EN
      idle_arm_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      hold_dat_q   <= hold_dat_d;
      hold_full_q  <= hold_full_d;
      hold_last_q  <= hold_last_d;
      shift_q      <= shift_d;
      shift_last_q <= shift_last_d;
      bit_idx_q    <= bit_idx_d;
      kick_q       <= kick_d;
      lat_cnt_q    <= lat_cnt_d;
      rdy_en_q     <= rdy_en_d;
`ifdef LED_ENC_IDLE_LATCH_EN
      idle_arm_q   <= idle_arm_d;
`endif
    end
  end

endmodule

// File: tb/tb_led_bit_encoder.sv
// Self-checking bench for led_bit_encoder: per-bit high widths via a scoreboard queue,
// frame/underrun outcomes from a vector table, plus back-to-back, latch-overlap and reset sequences.
// Honors LED_ENC_IDLE_LATCH_EN when expecting idle-timeout frame_done pulses.
module tb_led_bit_encoder;

  localparam int T0H = 16;
  localparam int T1H = 32;
  localparam int BIT = 50;
  localparam int LAT = 2000;
`ifdef LED_ENC_IDLE_LATCH_EN
  localparam int IDLE_FD = 1;
`else
  localparam int IDLE_FD = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_last = 1'b0;
  logic       data_ready;
  logic       led_out;
  logic       busy;
  logic       frame_done;
  logic       underrun;

  led_bit_encoder #(
    .T0H_CYC   (T0H),
    .T1H_CYC   (T1H),
    .BIT_CYC   (BIT),
    .LATCH_CYC (LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_last  (data_last),
    .data_ready (data_ready),
    .led_out    (led_out),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard of expected high widths, one entry per emitted bit.
  int exp_q[$];

  bit   mon_on = 1'b0;
  logic prev_led = 1'b0;
  int   hi_cnt = 0;
  int   last_rise = -100000;
  int   rise_cnt = 0;
  int   fd_cnt = 0;
  int   fd_cyc = 0;
  int   ur_cnt = 0;
  int   ur_cyc = 0;
  logic led_at_ur = 1'b0;

  // Monitor on the falling edge: pulse counters, bit widths and bit periods.
  always @(negedge clk) begin
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (underrun) begin
      ur_cnt++;
      ur_cyc = cyc;
      led_at_ur = led_out;
    end
    if (mon_on) begin
      if (led_out && !prev_led) begin
        rise_cnt++;
        if (cyc - last_rise < 2 * BIT) check("bit_period", cyc - last_rise, BIT);
        last_rise = cyc;
        hi_cnt = 0;
      end
      if (led_out) hi_cnt++;
      if (!led_out && prev_led) begin
        if (exp_q.size() == 0) check("bit_expected", exp_q.size(), 1);
        else check("high_width", hi_cnt, exp_q.pop_front());
      end
      prev_led = led_out;
    end else begin
      prev_led = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Offer a byte, wait (bounded) for acceptance; returns the cycle of the accepting edge.
  task automatic send_byte(input logic [7:0] d, input logic l, input bit push, output int acc);
    int n;
    n = 0;
    acc = -1;
    @(negedge clk);
    data_in = d;
    data_last = l;
    data_valid = 1'b1;
    while (!data_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!data_ready) begin
      check("byte_accepted", data_ready, 1);
    end else begin
      @(posedge clk);
      #1 acc = cyc;
      if (push) for (int i = 7; i >= 0; i--) exp_q.push_back(d[i] ? T1H : T0H);
    end
    @(negedge clk);
    data_valid = 1'b0;
    data_last = 1'b1;   // ignored while data_valid is low
    data_in = 8'h5A;
  endtask

  task automatic wait_fd(input int base, input int budget);
    int n;
    n = 0;
    while (fd_cnt == base && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("frame_done_seen", int'(fd_cnt > base), 1);
  endtask

  task automatic wait_ur(input int base, input int budget);
    int n;
    n = 0;
    while (ur_cnt == base && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("underrun_seen", int'(ur_cnt > base), 1);
  endtask

  typedef struct {
    logic [7:0] dat;
    logic       last;
    int         exp_fd;
    int         exp_ur;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int fd0, ur0, r0, acc, acc2, n, fdc;

    vecs[0] = '{dat: 8'hA5, last: 1'b1, exp_fd: 1,       exp_ur: 0};
    vecs[1] = '{dat: 8'h3C, last: 1'b1, exp_fd: 1,       exp_ur: 0};
    vecs[2] = '{dat: 8'h80, last: 1'b0, exp_fd: IDLE_FD, exp_ur: 1};
    vecs[3] = '{dat: 8'h00, last: 1'b1, exp_fd: 1,       exp_ur: 0};
    vecs[4] = '{dat: 8'hC3, last: 1'b0, exp_fd: IDLE_FD, exp_ur: 1};

    // Reset state.
    tick(3);
    check("reset_led_out", led_out, 0);
    check("reset_busy", busy, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_underrun", underrun, 0);
    check("reset_data_ready", data_ready, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 check("ready_after_reset", data_ready, 1);
    mon_on = 1'b1;

    // Single-byte frames and underruns from the vector table.
    for (int v = 0; v < 5; v++) begin
      fd0 = fd_cnt;
      ur0 = ur_cnt;
      send_byte(vecs[v].dat, vecs[v].last, 1'b1, acc);
      n = 0;
      while (!led_out && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("start_latency", cyc - acc, 2);
      if (vecs[v].last) begin
        wait_fd(fd0, 8 * BIT + LAT + 100);
        check("latch_length", fd_cyc - last_rise, BIT + LAT - 1);
      end else begin
        wait_ur(ur0, 8 * BIT + 100);
        check("underrun_at_byte_end", ur_cyc - last_rise, BIT - 1);
        check("led_low_at_underrun", led_at_ur, 0);
      end
      tick(LAT + 100);
      check("frame_done_pulses", fd_cnt - fd0, vecs[v].exp_fd);
      check("underrun_pulses", ur_cnt - ur0, vecs[v].exp_ur);
      check("idle_led_low", led_out, 0);
      check("idle_busy_low", busy, 0);
    end

    // Back-to-back 0xFF, 0x00(last): 16 contiguous bits, holding register backs up.
    fd0 = fd_cnt;
    ur0 = ur_cnt;
    r0  = rise_cnt;
    send_byte(8'hFF, 1'b0, 1'b1, acc);
    send_byte(8'h00, 1'b1, 1'b1, acc2);
    tick(100);
    check("b2b_ready_low_hold_full", data_ready, 0);
    check("b2b_busy", busy, 1);
    wait_fd(fd0, 16 * BIT + LAT + 100);
    check("b2b_bit_count", rise_cnt - r0, 16);
    check("b2b_no_underrun", ur_cnt - ur0, 0);
    tick(20);
    check("b2b_single_frame_done", fd_cnt - fd0, 1);

    // Byte offered during LATCH starts the cycle after frame_done.
    fd0 = fd_cnt;
    send_byte(8'h01, 1'b1, 1'b1, acc);
    tick(8 * BIT + 50);
    check("latch_busy", busy, 1);
    check("latch_led_low", led_out, 0);
    send_byte(8'h01, 1'b1, 1'b1, acc2);
    check("latch_accept", int'(acc2 >= 0), 1);
    wait_fd(fd0, LAT + 100);
    fdc = fd_cyc;
    n = 0;
    while (!led_out && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("rise_after_latch", cyc - fdc, 1);
    wait_fd(fd0 + 1, 8 * BIT + LAT + 100);
    tick(20);
    check("latch_overlap_frames", fd_cnt - fd0, 2);

    // Reset during bit 3 of 0xAA aborts silently.
    mon_on = 1'b0;
    fd0 = fd_cnt;
    send_byte(8'hAA, 1'b1, 1'b0, acc);
    tick(2 + 3 * BIT + 8);
    check("pre_reset_led_high", led_out, 1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("abort_led_out", led_out, 0);
    check("abort_busy", busy, 0);
    check("abort_data_ready", data_ready, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 check("abort_ready_after_release", data_ready, 1);
    tick(LAT + 200);
    check("abort_no_frame_done", fd_cnt - fd0, 0);
    check("abort_led_stays_low", led_out, 0);
    mon_on = 1'b1;

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
